frame_scrambler: RTL

Transmit-side 802.11a data scrambler; the counterpart of the receiver's descrambler.
- Scrambles the serial SERVICE+PSDU bit stream with the x^7+x^4+1 LFSR.
- Appends the 6 zero tail bits, which are not scrambled.
- Sits in the transmitter between the frame assembler and the convolutional encoder, with valid/ready handshakes on both sides.

---
 rtl/frame_scrambler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/frame_scrambler.sv
// 802.11a transmit scrambler: x^7+x^4+1 LFSR over SERVICE+PSDU, then 6 unscrambled zero tail bits.
// Valid/ready on both sides, with a single registered output stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for Start; seed and length are captured here
// SCRAMBLE | accepting payload bits, scrambling them, counting down cnt
// TAIL     | loading 6 zero tail bits; LFSR frozen
// DRAIN    | waiting for the last tail bit to leave, then pulse Done
module frame_scrambler #(
    parameter int           LEN_WIDTH    = 16,
    parameter logic [6:0]   SEED_DEFAULT = 7'b1011101
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [6:0]           Seed,
    input  logic [LEN_WIDTH-1:0] Length,
    input  logic                 In_valid,
    input  logic                 In_data,
    output logic                 In_ready,
    output logic                 Out_valid,
    output logic                 Out_data,
    input  logic                 Out_ready,
    output logic                 Busy,
    output logic                 Done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCRAMBLE = 2'd1,
        TAIL     = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             lfsr_q, lfsr_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2:0]             tcnt_q, tcnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_data_q, out_data_d;
    logic                   done_q, done_d;

    logic                   can_load;
    logic                   feedback;
    logic                   in_hs;

    assign can_load = !out_valid_q || Out_ready;
    assign feedback = lfsr_q[6] ^ lfsr_q[3];
    assign In_ready = (state_q == SCRAMBLE) && can_load;
    assign in_hs    = In_valid && In_ready;

    assign Out_valid = out_valid_q;
    assign Out_data  = out_data_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        // A consumed output empties the register unless something is loaded below.
        out_valid_d = out_valid_q && !Out_ready;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    lfsr_d  = (Seed == 7'd0) ? SEED_DEFAULT : Seed;
                    cnt_d   = Length;
                    tcnt_d  = 3'd0;
                    state_d = (Length != '0) ? SCRAMBLE : TAIL;
                end
            end
            SCRAMBLE: begin
                if (in_hs) begin
                    out_data_d  = In_data ^ feedback;
                    out_valid_d = 1'b1;
                    lfsr_d      = {lfsr_q[5:0], feedback};
                    cnt_d       = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = TAIL;
                        tcnt_d  = 3'd0;
                    end
                end
            end
            TAIL: begin
                if (can_load) begin
                    out_data_d  = 1'b0;
                    out_valid_d = 1'b1;
                    tcnt_d      = tcnt_q + 3'd1;
                    if (tcnt_q == 3'd5) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && Out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            lfsr_q      <= 7'd0;
            cnt_q       <= '0;
            tcnt_q      <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

endmodule
